// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin sharing of a byte-wide sync-read ROM port, assembling big-endian 32-bit words.
// Optional misaligned-request rejection is enabled by defining IMEM_ALIGN_CHECK_EN.
module imem_fetch_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [ADDRESS_WIDTH-1:0]  req0_addr,
    output logic                      req0_ready,
    output logic                      rsp0_valid,
    input  logic                      rsp0_ready,
    output logic [4*DATA_WIDTH-1:0]   rsp0_data,
    input  logic                      req1_valid,
    input  logic [ADDRESS_WIDTH-1:0]  req1_addr,
    output logic                      req1_ready,
    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
    output logic [4*DATA_WIDTH-1:0]   rsp1_data,
    output logic                      rsp_err,
    output logic                      mem_en,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      busy
);
    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
    state_t state, state_nx;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [3:0][DATA_WIDTH-1:0] word;
    logic [2:0] k;
    logic owner, last, err, gnt1, accept, misaligned, rsp_fire;
    assign gnt1 = req1_valid && (!req0_valid || !last);
    assign accept = req0_ready || req1_ready;
`ifdef IMEM_ALIGN_CHECK_EN
    assign misaligned = (gnt1 ? req1_addr[1:0] : req0_addr[1:0]) != 2'b00;
`else
    assign misaligned = 1'b0;
`endif
    assign rsp0_data = word;
    assign rsp1_data = word;
    assign rsp_err = err;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_fire = 1'b0;
        mem_en = 1'b0;
        mem_addr = '0;
        case (state)
            IDLE: begin
                req0_ready = rst_n && req0_valid && !gnt1;
                req1_ready = rst_n && gnt1;
                if (req0_valid || req1_valid) state_nx = misaligned ? RESP : READ;
            end
            READ: begin
                mem_en = !k[2];
                mem_addr = mem_en ? addr + ADDRESS_WIDTH'(k[1:0]) : '0;
                if (k[2]) state_nx = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                rsp_fire = owner ? rsp1_ready : rsp0_ready;
                if (rsp_fire) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // k counts issued reads; the byte for read k-1 arrives while k is 1..4 and lands in lane 3-(k-1)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr <= '0;
            word <= '0;
            k <= '0;
            owner <= 1'b0;
            last <= 1'b1;
            err <= 1'b0;
        end else begin
            if (accept) begin
                addr <= gnt1 ? req1_addr : req0_addr;
                owner <= gnt1;
                last <= gnt1;
                k <= '0;
                err <= misaligned;
                if (misaligned) word <= '0;
            end else if (state == READ) begin
                k <= k + 3'd1;
                if (k != 3'd0) word[2'd0 - k[1:0]] <= mem_rdata;
            end
            if (rsp_fire) err <= 1'b0;
        end
endmodule
